// File: rtl/nibble_add_sched.sv
// Two-requester scheduler that adds NIBBLES*4-bit operands through one shared 4-bit adder slice, LSB nibble first.
// Latency NIBBLES edges after accept (plus en=0 stalls); result is held in DONE until res_ready, no grants meanwhile.
module nibble_add_sched #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [4*NIBBLES-1:0]   req0_a,
  input  logic [4*NIBBLES-1:0]   req0_b,
  input  logic                   req0_cin,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [4*NIBBLES-1:0]   req1_a,
  input  logic [4*NIBBLES-1:0]   req1_b,
  input  logic                   req1_cin,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES-1:0]   res_sum,
  output logic                   res_cout,
  output logic                   res_id,
  output logic                   busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    a_r, b_r;
  logic            carry;
  logic [IW-1:0]   idx;
  logic            last_grant;
  logic            gnt0, gnt1;
  logic            acc0, acc1;
  logic            last_nib;
  logic [4:0]      nib;

  // Round-robin: on a tie, the requester that was not granted last wins.
  assign gnt0 = req0_valid && (!req1_valid || last_grant);
  assign gnt1 = req1_valid && (!req0_valid || !last_grant);

  assign acc0     = req0_valid && req0_ready;
  assign acc1     = req1_valid && req1_ready;
  assign last_nib = (idx == IW'(NIBBLES - 1));
  assign nib      = {1'b0, a_r[idx*4 +: 4]} + {1'b0, b_r[idx*4 +: 4]} + {4'b0, carry};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc0 || acc1)       state_nx = RUN;
      RUN:     if (en && last_nib)     state_nx = DONE;
      DONE:    if (res_ready)          state_nx = IDLE;
      default:                         state_nx = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == IDLE) && en && gnt0;
    req1_ready = (state == IDLE) && en && gnt1;
    res_valid  = (state == DONE);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r        <= '0;
      b_r        <= '0;
      carry      <= 1'b0;
      idx        <= '0;
      last_grant <= 1'b1;
      res_sum    <= '0;
      res_cout   <= 1'b0;
      res_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc0) begin
            a_r        <= req0_a;
            b_r        <= req0_b;
            carry      <= req0_cin;
            idx        <= '0;
            res_id     <= 1'b0;
            last_grant <= 1'b0;
          end else if (acc1) begin
            a_r        <= req1_a;
            b_r        <= req1_b;
            carry      <= req1_cin;
            idx        <= '0;
            res_id     <= 1'b1;
            last_grant <= 1'b1;
          end
        end
        RUN: begin
          if (en) begin
            res_sum[idx*4 +: 4] <= nib[3:0];
            carry               <= nib[4];
            idx                 <= idx + 1'b1;
            if (last_nib) res_cout <= nib[4];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_sched.sv
// Directed self-checking bench for nibble_add_sched (NIBBLES=4).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_nibble_add_sched;

  logic        clk = 1'b0;
  logic        rst, en;
  logic        req0_valid, req0_ready, req0_cin;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req1_a, req1_b;
  logic        res_valid, res_ready, res_cout, res_id, busy;
  logic [15:0] res_sum;

  int checks   = 0;
  int failures = 0;

  nibble_add_sched #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
    .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation with res_ready=1 and en=1; returns to IDLE at the end.
  task automatic do_op(input logic who, input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [15:0] es, input logic ec, input string tag);
    int n;
    if (!who) begin req0_valid = 1; req0_a = a; req0_b = b; req0_cin = c; end
    else      begin req1_valid = 1; req1_a = a; req1_b = b; req1_cin = c; end
    #1;
    chk({tag, "_ready"}, {req1_ready, req0_ready}, who ? 2'b10 : 2'b01);
    tick();
    req0_valid = 0; req1_valid = 0;
    req0_a = 16'hDEAD; req1_a = 16'hBEEF; req0_cin = ~c; req1_cin = ~c;
    n = 0;
    while (!res_valid && n < 20) begin
      chk({tag, "_busy"}, busy, 1'b1);
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_sum"}, res_sum, es);
    chk({tag, "_cout"}, res_cout, ec);
    chk({tag, "_id"}, res_id, who);
    tick();
    chk({tag, "_valid_drop"}, res_valid, 1'b0);
    chk({tag, "_sum_held"}, res_sum, es);
  endtask

  // One arbitrated round with requests left asserted; readies must stay low in RUN/DONE.
  task automatic arb_round(input logic [1:0] exp_rdy, input logic exp_id, input string tag);
    #1;
    chk({tag, "_grant"}, {req1_ready, req0_ready}, exp_rdy);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_rdy_run"}, {req1_ready, req0_ready}, 2'b00);
      tick();
    end
    chk({tag, "_valid"}, res_valid, 1'b1);
    chk({tag, "_id"}, res_id, exp_id);
    chk({tag, "_rdy_done"}, {req1_ready, req0_ready}, 2'b00);
    tick();
  endtask

  initial begin
    int n;
    rst = 1; en = 1; res_ready = 1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_cin = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_cin = 0;
    tick(); tick();
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sum", res_sum, 16'h0000);
    chk("rst_cout", res_cout, 1'b0);
    chk("rst_id", res_id, 1'b0);
    rst = 0;

    // Single op and carry chains
    do_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, "single");
    do_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "carry1");
    do_op(1'b1, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, "carry2");

    // Arbitration from reset: 0,1,0,1 then req1 alone twice
    rst = 1; tick(); rst = 0;
    req0_valid = 1; req1_valid = 1;
    req0_a = 16'h0001; req0_b = 16'h0001; req1_a = 16'h0002; req1_b = 16'h0002;
    arb_round(2'b01, 1'b0, "arb0");
    arb_round(2'b10, 1'b1, "arb1");
    arb_round(2'b01, 1'b0, "arb2");
    arb_round(2'b10, 1'b1, "arb3");
    req0_valid = 0;
    arb_round(2'b10, 1'b1, "solo0");
    arb_round(2'b10, 1'b1, "solo1");
    req1_valid = 0;

    // Backpressure: hold result 5 cycles, a competing request must not be granted
    req0_valid = 1; req0_a = 16'h1234; req0_b = 16'h0FFF; req0_cin = 0;
    res_ready = 0;
    #1;
    chk("bp_accept", req0_ready, 1'b1);
    tick();
    req0_valid = 0; req1_valid = 1;
    repeat (4) tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", res_valid, 1'b1);
      chk("bp_sum", res_sum, 16'h2233);
      chk("bp_cout", res_cout, 1'b0);
      chk("bp_id", res_id, 1'b0);
      chk("bp_rdy", {req1_ready, req0_ready}, 2'b00);
      tick();
    end
    res_ready = 1; req1_valid = 0;
    tick();
    chk("bp_release", res_valid, 1'b0);
    chk("bp_idle", busy, 1'b0);

    // Enable stall after nibble 1 completes
    req0_valid = 1; req0_a = 16'h1234; req0_b = 16'h0FFF; req0_cin = 0;
    #1;
    chk("stall_accept", req0_ready, 1'b1);
    tick();
    req0_valid = 0;
    tick(); tick();
    en = 0;
    repeat (3) begin
      tick();
      chk("stall_hold_valid", res_valid, 1'b0);
      chk("stall_hold_busy", busy, 1'b1);
    end
    en = 1;
    n = 5;
    while (!res_valid && n < 30) begin
      tick();
      n++;
    end
    chk("stall_latency", n, 7);
    chk("stall_sum", res_sum, 16'h2233);
    chk("stall_cout", res_cout, 1'b0);
    tick();
    en = 0; req0_valid = 1;
    #1;
    chk("en0_idle_rdy", req0_ready, 1'b0);
    tick();
    chk("en0_idle_busy", busy, 1'b0);
    en = 1;

    // Reset mid-op at idx=2; last_grant=0 so the tie goes to req1 first
    req1_valid = 1; req1_a = 16'h1111; req1_b = 16'h2222; req1_cin = 0;
    #1;
    chk("mid_grant1", {req1_ready, req0_ready}, 2'b10);
    tick();
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mid_busy", busy, 1'b0);
    chk("mid_valid", res_valid, 1'b0);
    chk("mid_sum", res_sum, 16'h0000);
    chk("mid_id", res_id, 1'b0);
    #1;
    chk("mid_regrant0", {req1_ready, req0_ready}, 2'b01);
    req0_valid = 0; req1_valid = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
